// File: rtl/noc_pkg.sv
// Packet layout shared by the ring: router, clients and network interfaces.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package noc_pkg;

    localparam int DATA_LSB = 0;

    // Packet is {valid, ctrl, addr[A_W], data[D_W]}, MSB first.
    function automatic int pkt_w(input int a_w, input int d_w);
        return a_w + d_w + 2;
    endfunction

    function automatic int valid_bit(input int a_w, input int d_w);
        return a_w + d_w + 1;
    endfunction

    function automatic int ctrl_bit(input int a_w, input int d_w);
        return a_w + d_w;
    endfunction

    function automatic int addr_lsb(input int d_w);
        return d_w;
    endfunction

endpackage

// File: rtl/deflect_ni_if.sv
// Client injection handshake, router link pair and ejection port of one NI.
// Latency: none (wiring only).
// Backpressure: inj_valid/inj_ready on injection; ejection and link have none.
interface deflect_ni_if #(
    parameter int A_W = 3,
    parameter int D_W = 32
);
    import noc_pkg::*;

    localparam int P_W = pkt_w(A_W, D_W);

    logic           inj_valid;
    logic           inj_ready;
    logic [A_W-1:0] inj_addr;
    logic [D_W-1:0] inj_data;
    logic [P_W-1:0] o;
    logic [P_W-1:0] i;
    logic           ej_valid;
    logic           ej_ctrl;
    logic [A_W-1:0] ej_addr;
    logic [D_W-1:0] ej_data;

    modport slave (
        input  inj_valid, inj_addr, inj_data, o,
        output inj_ready, i, ej_valid, ej_ctrl, ej_addr, ej_data
    );

    modport master (
        output inj_valid, inj_addr, inj_data, o,
        input  inj_ready, i, ej_valid, ej_ctrl, ej_addr, ej_data
    );

endinterface

// File: rtl/ni_fifo.sv
// Synchronous first-word-fall-through FIFO holding pending injections.
// Latency: push visible at head after the push edge.
// Backpressure: caller must not push when full nor pop when empty.
module ni_fifo #(
    parameter int W     = 35,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: count gates every use of head.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/deflect_ni.sv
// Deflection-ring NI: queues client packets, injects into empty link slots, ejects arrivals.
// Latency: injection 1 cycle after push on an idle link; ejection 1 cycle. NI_STATS_EN adds counters.
// Backpressure: inj_ready = !full; link and ejection have none, ce low freezes all state.
module deflect_ni
    import noc_pkg::*;
#(
    parameter int N          = 2,
    parameter int D_W        = 32,
    parameter int A_W        = $clog2(N) + 1,
    parameter int POS        = 2,
    parameter int DEPTH      = 4,
    parameter int STARVE_LIM = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    deflect_ni_if.slave bus,
    output logic        misroute,
    output logic        starve
`ifdef NI_STATS_EN
    ,
    output logic [31:0] inj_count,
    output logic [31:0] ej_count
`endif
);
    localparam int P_W  = pkt_w(A_W, D_W);
    localparam int VB   = valid_bit(A_W, D_W);
    localparam int CB   = ctrl_bit(A_W, D_W);
    localparam int AL   = addr_lsb(D_W);
    localparam int SC_W = $clog2(STARVE_LIM + 1);

    logic           o_vld;
    logic           o_ctrl;
    logic [A_W-1:0] o_addr;
    logic [D_W-1:0] o_data;
    logic [A_W-1:0] head_addr;
    logic [D_W-1:0] head_data;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    logic [P_W-1:0] i_q;
    logic           ej_valid_q;
    logic           ej_ctrl_q;
    logic [A_W-1:0] ej_addr_q;
    logic [D_W-1:0] ej_data_q;
    logic [SC_W-1:0] wait_cnt;
    logic [SC_W-1:0] wait_nxt;

    assign o_vld  = bus.o[VB];
    assign o_ctrl = bus.o[CB];
    assign o_addr = bus.o[AL +: A_W];
    assign o_data = bus.o[DATA_LSB +: D_W];

    assign push = ce & bus.inj_valid & ~full;
    // A valid arriving message owns the slot, so the head only leaves on an empty slot.
    assign pop  = ce & ~o_vld & ~empty;

    ni_fifo #(
        .W     (A_W + D_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({bus.inj_addr, bus.inj_data}),
        .head  ({head_addr, head_data}),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        wait_nxt = wait_cnt;
        if (empty || pop)
            wait_nxt = '0;
        else if (wait_cnt != SC_W'(STARVE_LIM))
            wait_nxt = wait_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_q        <= '0;
            ej_valid_q <= 1'b0;
            ej_ctrl_q  <= 1'b0;
            ej_addr_q  <= '0;
            ej_data_q  <= '0;
            misroute   <= 1'b0;
            wait_cnt   <= '0;
            starve     <= 1'b0;
        end else if (ce) begin
            wait_cnt <= wait_nxt;
            starve   <= (wait_nxt == SC_W'(STARVE_LIM));
            if (o_vld) begin
                i_q        <= '0;
                ej_valid_q <= 1'b1;
                ej_ctrl_q  <= o_ctrl;
                ej_addr_q  <= o_addr;
                ej_data_q  <= o_data;
                if (o_addr != A_W'(POS)) misroute <= 1'b1;
            end else begin
                ej_valid_q <= 1'b0;
                i_q        <= empty ? '0 : {1'b1, 1'b0, head_addr, head_data};
            end
        end
    end

`ifdef NI_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inj_count <= '0;
            ej_count  <= '0;
        end else begin
            if (pop)         inj_count <= inj_count + 32'd1;
            if (ce && o_vld) ej_count  <= ej_count + 32'd1;
        end
    end
`endif

    assign bus.inj_ready = ~full;
    assign bus.i         = i_q;
    assign bus.ej_valid  = ej_valid_q;
    assign bus.ej_ctrl   = ej_ctrl_q;
    assign bus.ej_addr   = ej_addr_q;
    assign bus.ej_data   = ej_data_q;

endmodule

// File: tb/tb_deflect_ni.sv
// Bench for deflect_ni (N=4, D_W=32, A_W=3, POS=2, DEPTH=4, STARVE_LIM=8) against a queue-based reference.
module tb_deflect_ni;
    localparam int POS = 2;
    localparam int LIM = 8;
    localparam int DEP = 4;

    logic clk;
    logic rst;
    logic ce;
    logic misroute;
    logic starve;
`ifdef NI_STATS_EN
    logic [31:0] inj_count;
    logic [31:0] ej_count;
`endif

    deflect_ni_if #(.A_W(3), .D_W(32)) bus ();

    deflect_ni #(
        .N(4), .D_W(32), .A_W(3), .POS(POS), .DEPTH(DEP), .STARVE_LIM(LIM)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce),
        .bus      (bus),
        .misroute (misroute),
        .starve   (starve)
`ifdef NI_STATS_EN
        ,
        .inj_count (inj_count),
        .ej_count  (ej_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: the queue of pending {addr,data} and the observable outputs.
    logic [34:0] q[$];
    logic [36:0] m_i;
    logic        m_ejv, m_ejc, m_mis;
    logic [2:0]  m_eja;
    logic [31:0] m_ejd;
    int          m_wait;
    logic [31:0] m_ninj, m_nej;

    task automatic model_clear();
        q.delete();
        m_i = '0; m_ejv = 0; m_ejc = 0; m_eja = '0; m_ejd = '0;
        m_mis = 0; m_wait = 0; m_ninj = '0; m_nej = '0;
    endtask

    // Advance the reference by one edge using the inputs now applied, then clock the DUT.
    task automatic tick();
        logic [34:0] hd;
        bit ne, popd, pushd;
        if (rst) begin
            model_clear();
        end else if (ce) begin
            ne    = (q.size() != 0);
            pushd = bus.inj_valid && (q.size() < DEP);
            popd  = 0;
            if (bus.o[36]) begin
                m_i = '0; m_ejv = 1; m_ejc = bus.o[35]; m_eja = bus.o[34:32]; m_ejd = bus.o[31:0];
                if (m_eja != 3'(POS)) m_mis = 1;
                m_nej = m_nej + 1;
            end else if (ne) begin
                hd = q.pop_front();
                m_i = {2'b10, hd}; m_ejv = 0; m_ninj = m_ninj + 1; popd = 1;
            end else begin
                m_i = '0; m_ejv = 0;
            end
            if (!ne || popd) m_wait = 0;
            else if (m_wait < LIM) m_wait++;
            if (pushd) q.push_back({bus.inj_addr, bus.inj_data});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1; ce = 1; bus.inj_valid = 0; bus.inj_addr = '0; bus.inj_data = '0; bus.o = '0;
        model_clear();
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.i !== 37'd0) begin n_bad++; $display("FAIL reset_i: got %h want 0", bus.i); end
        n_cmp++; if (bus.ej_valid !== 1'b0) begin n_bad++; $display("FAIL reset_ejv: got %b want 0", bus.ej_valid); end
        n_cmp++; if (misroute !== 1'b0) begin n_bad++; $display("FAIL reset_misroute: got %b want 0", misroute); end
        n_cmp++; if (starve !== 1'b0) begin n_bad++; $display("FAIL reset_starve: got %b want 0", starve); end
        n_cmp++; if (bus.inj_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", bus.inj_ready); end
`ifdef NI_STATS_EN
        n_cmp++; if (inj_count !== 32'd0 || ej_count !== 32'd0) begin n_bad++; $display("FAIL reset_stats: got %0d/%0d want 0/0", inj_count, ej_count); end
`endif
        rst = 0;
    endtask

    task automatic test_idle_link();
        logic [36:0] exp;
        exp = {1'b1, 1'b0, 3'd1, 32'hA5};
        bus.o = '0; bus.inj_valid = 1; bus.inj_addr = 3'd1; bus.inj_data = 32'hA5;
        tick();
        bus.inj_valid = 0;
        n_cmp++; if (bus.i !== 37'd0) begin n_bad++; $display("FAIL idle_push_edge: got %h want 0", bus.i); end
        tick();
        n_cmp++; if (bus.i !== exp) begin n_bad++; $display("FAIL idle_inject: got %h want %h", bus.i, exp); end
        tick();
        n_cmp++; if (bus.i !== 37'd0) begin n_bad++; $display("FAIL idle_after: got %h want 0", bus.i); end
    endtask

    task automatic test_busy_link();
        logic [34:0] pk[3];
        int ej_seen;
        ej_seen = 0;
        for (int c = 0; c < 5; c++) begin
            bus.o = {1'b1, 1'b0, 3'(POS), 32'($urandom)};
            if (c < 3) begin
                bus.inj_valid = 1; bus.inj_addr = 3'($urandom); bus.inj_data = $urandom;
                pk[c] = {bus.inj_addr, bus.inj_data};
            end else bus.inj_valid = 0;
            tick();
            if (bus.ej_valid === 1'b1) ej_seen++;
            n_cmp++; if (bus.i[36] !== 1'b0) begin n_bad++; $display("FAIL busy_no_inject c%0d: got %h want valid=0", c, bus.i); end
            n_cmp++; if (bus.ej_data !== m_ejd) begin n_bad++; $display("FAIL busy_ej_data c%0d: got %h want %h", c, bus.ej_data, m_ejd); end
        end
        n_cmp++; if (ej_seen !== 5) begin n_bad++; $display("FAIL busy_ej_pulses: got %0d want 5", ej_seen); end
        bus.inj_valid = 0; bus.o = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if (bus.i !== {2'b10, pk[k]}) begin n_bad++; $display("FAIL busy_order k%0d: got %h want %h", k, bus.i, {2'b10, pk[k]}); end
        end
        tick();
        n_cmp++; if (bus.i !== 37'd0) begin n_bad++; $display("FAIL busy_drained: got %h want 0", bus.i); end
    endtask

    task automatic test_full();
        logic [34:0] pk[5];
        bus.o = {1'b1, 1'b0, 3'(POS), 32'h0};
        for (int k = 0; k < 5; k++) begin
            bus.inj_valid = 1; bus.inj_addr = 3'($urandom); bus.inj_data = $urandom;
            pk[k] = {bus.inj_addr, bus.inj_data};
            n_cmp++; if (bus.inj_ready !== (k < 4)) begin n_bad++; $display("FAIL full_ready k%0d: got %b want %b", k, bus.inj_ready, (k < 4)); end
            tick();
        end
        bus.inj_valid = 0;
        n_cmp++; if (bus.inj_ready !== 1'b0) begin n_bad++; $display("FAIL full_held: got %b want 0", bus.inj_ready); end
        bus.o = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++; if (bus.i !== {2'b10, pk[k]}) begin n_bad++; $display("FAIL full_drain k%0d: got %h want %h", k, bus.i, {2'b10, pk[k]}); end
        end
        tick();
        n_cmp++; if (bus.i !== 37'd0) begin n_bad++; $display("FAIL full_fifth_dropped: got %h want 0", bus.i); end
    endtask

    task automatic test_starvation();
        bus.o = {1'b1, 1'b0, 3'(POS), 32'h5};
        bus.inj_valid = 1; bus.inj_addr = 3'd0; bus.inj_data = 32'h77;
        tick();
        bus.inj_valid = 0;
        for (int k = 1; k <= LIM; k++) begin
            tick();
            n_cmp++; if (starve !== (k == LIM)) begin n_bad++; $display("FAIL starve_blocked k%0d: got %b want %b", k, starve, (k == LIM)); end
        end
        bus.o = '0;
        tick();
        n_cmp++; if (starve !== 1'b0) begin n_bad++; $display("FAIL starve_clear: got %b want 0", starve); end
        n_cmp++; if (bus.i !== {2'b10, 3'd0, 32'h77}) begin n_bad++; $display("FAIL starve_pop: got %h want %h", bus.i, {2'b10, 3'd0, 32'h77}); end
        tick();
    endtask

    task automatic test_misroute();
        bus.o = {1'b1, 1'b0, 3'd3, 32'h1};
        tick();
        n_cmp++; if (bus.ej_valid !== 1'b1) begin n_bad++; $display("FAIL mis_ejv: got %b want 1", bus.ej_valid); end
        n_cmp++; if (bus.ej_addr !== 3'd3) begin n_bad++; $display("FAIL mis_addr: got %0d want 3", bus.ej_addr); end
        n_cmp++; if (misroute !== 1'b1) begin n_bad++; $display("FAIL mis_set: got %b want 1", misroute); end
        for (int k = 0; k < 4; k++) begin
            bus.o = {1'b1, 1'b0, 3'(POS), 32'($urandom)};
            tick();
            n_cmp++; if (misroute !== 1'b1) begin n_bad++; $display("FAIL mis_sticky k%0d: got %b want 1", k, misroute); end
        end
        bus.o = '0;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            ce = ($urandom_range(0, 7) != 0);
            bus.inj_valid = $urandom_range(0, 1);
            bus.inj_addr = 3'($urandom); bus.inj_data = $urandom;
            if ($urandom_range(0, 9) < 4)
                bus.o = {1'b1, 1'($urandom), ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'(POS), 32'($urandom)};
            else
                bus.o = {1'b0, 36'($urandom)};
            n_cmp++; if (bus.inj_ready !== (q.size() < DEP)) begin n_bad++; $display("FAIL rnd_ready c%0d: got %b want %b", c, bus.inj_ready, (q.size() < DEP)); end
            tick();
            n_cmp++; if (bus.i !== m_i) begin n_bad++; $display("FAIL rnd_i c%0d: got %h want %h", c, bus.i, m_i); end
            n_cmp++; if (bus.ej_valid !== m_ejv) begin n_bad++; $display("FAIL rnd_ejv c%0d: got %b want %b", c, bus.ej_valid, m_ejv); end
            if (m_ejv) begin
                n_cmp++; if ({bus.ej_ctrl, bus.ej_addr, bus.ej_data} !== {m_ejc, m_eja, m_ejd}) begin
                    n_bad++; $display("FAIL rnd_ej c%0d: got %h want %h", c, {bus.ej_ctrl, bus.ej_addr, bus.ej_data}, {m_ejc, m_eja, m_ejd}); end
            end
            n_cmp++; if (starve !== (m_wait == LIM)) begin n_bad++; $display("FAIL rnd_starve c%0d: got %b want %b", c, starve, (m_wait == LIM)); end
            n_cmp++; if (misroute !== m_mis) begin n_bad++; $display("FAIL rnd_mis c%0d: got %b want %b", c, misroute, m_mis); end
`ifdef NI_STATS_EN
            n_cmp++; if (inj_count !== m_ninj || ej_count !== m_nej) begin n_bad++; $display("FAIL rnd_stats c%0d: got %0d/%0d want %0d/%0d", c, inj_count, ej_count, m_ninj, m_nej); end
`endif
        end
        ce = 1; bus.inj_valid = 0; bus.o = '0;
    endtask

    task automatic test_reset_mid();
        bus.o = {1'b1, 1'b0, 3'(POS), 32'h0};
        for (int k = 0; k < 3; k++) begin
            bus.inj_valid = 1; bus.inj_addr = 3'($urandom); bus.inj_data = $urandom;
            tick();
        end
        bus.inj_valid = 0; bus.o = '0;
        tick();
        n_cmp++; if (bus.i[36] !== 1'b1) begin n_bad++; $display("FAIL rstmid_inflight: got %h want valid=1", bus.i); end
        rst = 1;
        #1;
        model_clear();
        n_cmp++; if (bus.i !== 37'd0) begin n_bad++; $display("FAIL rstmid_i: got %h want 0", bus.i); end
        n_cmp++; if (bus.inj_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready: got %b want 1", bus.inj_ready); end
        n_cmp++; if (misroute !== 1'b0) begin n_bad++; $display("FAIL rstmid_mis: got %b want 0", misroute); end
`ifdef NI_STATS_EN
        n_cmp++; if (inj_count !== 32'd0 || ej_count !== 32'd0) begin n_bad++; $display("FAIL rstmid_stats: got %0d/%0d want 0/0", inj_count, ej_count); end
`endif
        @(negedge clk);
        rst = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++; if (bus.i !== 37'd0) begin n_bad++; $display("FAIL rstmid_stale k%0d: got %h want 0", k, bus.i); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_idle_link();
        test_busy_link();
        test_full();
        test_starvation();
        test_misroute();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
